// File: rtl/fifo_responder.sv
// fifo_responder: DEPTH-entry circular-buffer endpoint for the fifo port protocol.
// Define FIFO_RESPONDER_ERR_EN to add sticky overflow_err/underflow_err outputs.
module fifo_responder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_valid,
    output logic                         write_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         read_valid,
    output logic                         read_ready,
    output logic [WIDTH-1:0]             out_data,
`ifdef FIFO_RESPONDER_ERR_EN
    output logic                         overflow_err,
    output logic                         underflow_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wa, ra;

    // Readies decode only the registered count, so a full FIFO refuses writes
    // even when a read is accepted on the same edge (no pass-through).
    assign write_ready = (count_q != FULL);
    assign read_ready  = (count_q != '0);
    assign wa          = write_valid && write_ready;
    assign ra          = read_valid && read_ready;
    assign count       = count_q;
    assign out_data    = out_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        out_d   = out_q;
        if (wa) begin
            wp_d = wp_q + AW'(1);
        end
        if (ra) begin
            rp_d  = rp_q + AW'(1);
            out_d = mem_q[rp_q];
        end
        case ({wa, ra})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem_q[wp_q] <= in_data;
        end
    end

`ifdef FIFO_RESPONDER_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (write_valid & ~write_ready);
        udf_d = udf_q | (read_valid & ~read_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
`endif

endmodule

// File: tb/tb_fifo_responder.sv
// Directed self-checking bench for fifo_responder (WIDTH=32, DEPTH=16).
module tb_fifo_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_valid;
    logic        write_ready;
    logic [31:0] in_data;
    logic        read_valid;
    logic        read_ready;
    logic [31:0] out_data;
    logic [4:0]  count;
`ifdef FIFO_RESPONDER_ERR_EN
    logic        overflow_err;
    logic        underflow_err;
`endif

    int passed = 0;
    int total  = 0;

    fifo_responder #(.WIDTH(32), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .in_data     (in_data),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
        .out_data    (out_data),
`ifdef FIFO_RESPONDER_ERR_EN
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic        rv;
        logic [31:0] din;
        logic        ewr;
        logic        err;
        logic [31:0] ecnt;
        logic [31:0] edout;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input logic wv, input logic [31:0] din, input logic rv);
        write_valid = wv;
        in_data     = din;
        read_valid  = rv;
        @(posedge clk);
        #1;
        write_valid = 1'b0;
        read_valid  = 1'b0;
        in_data     = '0;
    endtask

    task automatic chk_state(input string tag, input logic ewr, input logic err,
                             input logic [31:0] ecnt);
        chk({tag, ".write_ready"}, 32'(write_ready), 32'(ewr));
        chk({tag, ".read_ready"},  32'(read_ready),  32'(err));
        chk({tag, ".count"},       32'(count),       ecnt);
    endtask

    initial begin
        int unsigned w;
        int          q[$];
        int          e;
        logic        wv, rv;

        // wv rv din  | write_ready read_ready count out_data
        vecs[0]  = '{1, 0, 791, 1, 1, 1, 0};
        vecs[1]  = '{0, 1, 0,   1, 0, 0, 791};
        vecs[2]  = '{0, 1, 0,   1, 0, 0, 791};   // read while empty: ignored
        vecs[3]  = '{1, 1, 5,   1, 1, 1, 791};   // empty: write does not feed read
        vecs[4]  = '{1, 1, 6,   1, 1, 1, 5};
        vecs[5]  = '{0, 1, 0,   1, 0, 0, 6};
        vecs[6]  = '{1, 0, 10,  1, 1, 1, 6};
        vecs[7]  = '{1, 0, 11,  1, 1, 2, 6};
        vecs[8]  = '{1, 0, 12,  1, 1, 3, 6};
        vecs[9]  = '{1, 0, 13,  1, 1, 4, 6};
        vecs[10] = '{1, 0, 14,  1, 1, 5, 6};
        vecs[11] = '{1, 1, 50,  1, 1, 5, 10};
        vecs[12] = '{0, 1, 0,   1, 1, 4, 11};
        vecs[13] = '{0, 1, 0,   1, 1, 3, 12};
        vecs[14] = '{0, 1, 0,   1, 1, 2, 13};
        vecs[15] = '{0, 1, 0,   1, 1, 1, 14};
        vecs[16] = '{0, 1, 0,   1, 0, 0, 50};

        write_valid = 1'b0;
        read_valid  = 1'b0;
        in_data     = '0;

        // Reset pulse with no clock edge in between.
        rst = 1'b1;
        #2;
        chk_state("rst_hold", 1'b1, 1'b0, 0);
        chk("rst_hold.out_data", out_data, 0);
        rst = 1'b0;
        #1;
        chk_state("rst_rel", 1'b1, 1'b0, 0);
        chk("rst_rel.out_data", out_data, 0);
`ifdef FIFO_RESPONDER_ERR_EN
        chk("rst_rel.overflow_err",  32'(overflow_err),  0);
        chk("rst_rel.underflow_err", 32'(underflow_err), 0);
`endif

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].wv, vecs[i].din, vecs[i].rv);
            chk_state($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].err, vecs[i].ecnt);
            chk($sformatf("vec%0d.out_data", i), out_data, vecs[i].edout);
        end

        // Fill to DEPTH, then an extra write is dropped.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i), 1'b0);
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
        end
        chk_state("full", 1'b0, 1'b1, 16);
        step(1'b1, 32'd99, 1'b0);
        chk_state("full_drop", 1'b0, 1'b1, 16);
        // Full: a same-edge read does not open space for the write.
        step(1'b1, 32'd77, 1'b1);
        chk_state("full_rw", 1'b1, 1'b1, 15);
        chk("full_rw.out_data", out_data, 0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            chk($sformatf("drain%0d.out_data", i), out_data, 32'(i));
            chk($sformatf("drain%0d.count", i), 32'(count), 32'(15 - i));
        end
        chk_state("drained", 1'b1, 1'b0, 0);

        // Interleaved traffic across pointer wrap, occupancy held at <=2.
        w = 0;
        while (w < 40) begin
            wv = 1'b1;
            rv = (q.size() >= 2);
            e  = 0;
            if (rv) e = q.pop_front();
            q.push_back(100 + int'(w));
            step(wv, 32'(100 + w), rv);
            w++;
            if (rv) chk($sformatf("wrap%0d.out_data", w), out_data, 32'(e));
            chk($sformatf("wrap%0d.count", w), 32'(count), 32'(q.size()));
        end
        chk("wrap_end.count", 32'(count), 2);

        // Asynchronous reset mid-operation, away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_state("midrst", 1'b1, 1'b0, 0);
        chk("midrst.out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_state("midrst_rel", 1'b1, 1'b0, 0);

`ifdef FIFO_RESPONDER_ERR_EN
        chk("err0.underflow_err", 32'(underflow_err), 0);
        chk("err0.overflow_err",  32'(overflow_err),  0);
        step(1'b0, '0, 1'b1);
        chk("err_udf.underflow_err", 32'(underflow_err), 1);
        chk("err_udf.overflow_err",  32'(overflow_err),  0);
        chk("err_udf.count", 32'(count), 0);
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0);
        step(1'b1, 32'd123, 1'b0);
        chk("err_ovf.overflow_err",  32'(overflow_err),  1);
        chk("err_ovf.underflow_err", 32'(underflow_err), 1);
        chk("err_ovf.count", 32'(count), 16);
        step(1'b0, '0, 1'b0);
        chk("err_hold.overflow_err",  32'(overflow_err),  1);
        chk("err_hold.underflow_err", 32'(underflow_err), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("err_rst.overflow_err",  32'(overflow_err),  0);
        chk("err_rst.underflow_err", 32'(underflow_err), 0);
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
